sclkfifolut_flags: RTL and testbench

Single-clock LUT-RAM FIFO, parametrised successor of the basic LUT FIFO. Adds a selectable first-word-fall-through read mode, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. Sits between producer and consumer blocks in the same clock domain wherever a shallow (2..64 words) elastic buffer with early-warning flags is needed.

---
 rtl/sclkfifolut_flags.sv | 120 ++++++++++++
 tb/tb_sclkfifolut_flags.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sclkfifolut_flags.sv
// Single-clock LUT-RAM FIFO with optional first-word-fall-through read,
// programmable almost-full/almost-empty flags, synchronous flush and sticky error flags.
module sclkfifolut_flags #(
  parameter int LOG2_FIFO_DEPTH = 3,
  parameter int FIFO_WIDTH      = 32,
  parameter bit FWFT            = 1'b0,
  parameter int AFULL_THRESH    = 2**LOG2_FIFO_DEPTH - 1,
  parameter int AEMPTY_THRESH   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclr,
  input  logic                       wen,
  input  logic [FIFO_WIDTH-1:0]      wdata,
  output logic                       wfull,
  output logic                       walmost_full,
  input  logic                       ren,
  output logic [FIFO_WIDTH-1:0]      rdata,
  output logic                       rempty,
  output logic                       ralmost_empty,
  output logic [LOG2_FIFO_DEPTH:0]   level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = LOG2_FIFO_DEPTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_L  = DEPTH[AW:0];
  localparam logic [AW:0] AFULL_L  = AFULL_THRESH[AW:0];
  localparam logic [AW:0] AEMPTY_L = AEMPTY_THRESH[AW:0];

  logic [FIFO_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic wr_acc, rd_acc, mem_we, rd_en;

  // Acceptance looks only at registered flags, so wen/ren never reach the flag outputs.
  assign wfull         = (level_q == DEPTH_L);
  assign rempty        = (level_q == '0);
  assign walmost_full  = (level_q >= AFULL_L);
  assign ralmost_empty = (level_q <= AEMPTY_L);
  assign level         = level_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

  assign wr_acc = wen && !wfull;
  assign rd_acc = ren && !rempty;
  assign mem_we = !sclr && wr_acc;
  assign rd_en  = !sclr && rd_acc;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (sclr) begin
      wptr_d      = '0;
      rptr_d      = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (wen && wfull)  overflow_d  = 1'b1;
      if (ren && rempty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately unreset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wptr_q] <= wdata;
  end

  if (FWFT) begin : g_fwft
    assign rdata = mem_q[rptr_q];
  end else begin : g_reg
    logic [FIFO_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (rd_en) rdata_d = mem_q[rptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sclkfifolut_flags.sv
// Directed bench for sclkfifolut_flags: depth-8 registered-read instance plus an FWFT instance.
module tb_sclkfifolut_flags;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclr = 1'b0, wen = 1'b0, ren = 1'b0;
  logic [31:0] wdata = '0;
  logic        wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
  logic [31:0] rdata;
  logic [3:0]  level;

  logic        f_sclr = 1'b0, f_wen = 1'b0, f_ren = 1'b0;
  logic [31:0] f_wdata = '0;
  logic        f_wfull, f_walmost_full, f_rempty, f_ralmost_empty, f_overflow, f_underflow;
  logic [31:0] f_rdata;
  logic [3:0]  f_level;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sclkfifolut_flags #(.LOG2_FIFO_DEPTH(3), .FIFO_WIDTH(32), .FWFT(1'b0),
                      .AFULL_THRESH(7), .AEMPTY_THRESH(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .wen(wen), .wdata(wdata),
    .wfull(wfull), .walmost_full(walmost_full), .ren(ren), .rdata(rdata),
    .rempty(rempty), .ralmost_empty(ralmost_empty), .level(level),
    .overflow(overflow), .underflow(underflow));

  sclkfifolut_flags #(.LOG2_FIFO_DEPTH(3), .FIFO_WIDTH(32), .FWFT(1'b1),
                      .AFULL_THRESH(7), .AEMPTY_THRESH(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .sclr(f_sclr), .wen(f_wen), .wdata(f_wdata),
    .wfull(f_wfull), .walmost_full(f_walmost_full), .ren(f_ren), .rdata(f_rdata),
    .rempty(f_rempty), .ralmost_empty(f_ralmost_empty), .level(f_level),
    .overflow(f_overflow), .underflow(f_underflow));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if ({rempty, wfull, ralmost_empty, walmost_full} !== 4'b1010) begin
      failures++; $display("FAIL reset_flags got=%b exp=1010", {rempty, wfull, ralmost_empty, walmost_full}); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", {overflow, underflow}); end
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", rdata); end
    checks++; if ({f_rempty, f_level} !== {1'b1, 4'd0}) begin failures++; $display("FAIL reset_fwft got=%b/%0d exp=1/0", f_rempty, f_level); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      wen = 1'b1; wdata = 32'(i);
      tick();
      checks++; if (level !== 4'(i)) begin failures++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level, i); end
      checks++; if ({wfull, walmost_full, ralmost_empty} !== {i == 8, i >= 7, i <= 1}) begin
        failures++; $display("FAIL fill_flags[%0d] got=%b exp=%b", i, {wfull, walmost_full, ralmost_empty}, {i == 8, i >= 7, i <= 1}); end
    end
    wdata = 32'd9;
    tick();
    wen = 1'b0;
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL overflow_level got=%0d exp=8", level); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_flag got=%b exp=1", overflow); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      ren = 1'b1;
      tick();
      checks++; if (rdata !== 32'(i)) begin failures++; $display("FAIL drain_rdata[%0d] got=%0d exp=%0d", i, rdata, i); end
      checks++; if (level !== 4'(8 - i)) begin failures++; $display("FAIL drain_level[%0d] got=%0d exp=%0d", i, level, 8 - i); end
      checks++; if (ralmost_empty !== (i >= 7)) begin failures++; $display("FAIL drain_aempty[%0d] got=%b exp=%b", i, ralmost_empty, i >= 7); end
    end
    tick();
    ren = 1'b0;
    checks++; if (rdata !== 32'd8) begin failures++; $display("FAIL underflow_rdata got=%0d exp=8", rdata); end
    checks++; if ({underflow, overflow, rempty, level} !== {3'b111, 4'd0}) begin
      failures++; $display("FAIL underflow_state got=%b%b%b/%0d exp=111/0", underflow, overflow, rempty, level); end
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL sclr_errclr got=%b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h77; exp_rd[1] = 32'd30; exp_rd[2] = 32'd31; exp_rd[3] = 32'd32;
    wen = 1'b1; wdata = 32'h77;
    tick();
    for (int k = 0; k < 4; k++) begin
      ren = 1'b1; wdata = 32'(30 + k);
      tick();
      checks++; if (level !== 4'd1) begin failures++; $display("FAIL b2b_level[%0d] got=%0d exp=1", k, level); end
      checks++; if (rdata !== exp_rd[k]) begin failures++; $display("FAIL b2b_rdata[%0d] got=%0h exp=%0h", k, rdata, exp_rd[k]); end
    end
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic test_simultaneous_edges();
    for (int i = 0; i < 7; i++) begin
      wen = 1'b1; wdata = 32'(40 + i);
      tick();
    end
    checks++; if (wfull !== 1'b1) begin failures++; $display("FAIL full_before got=%b exp=1", wfull); end
    ren = 1'b1; wdata = 32'd99;
    tick();
    wen = 1'b0; ren = 1'b0;
    checks++; if ({level, overflow} !== {4'd7, 1'b1}) begin failures++; $display("FAIL full_wr_rd got=%0d/%b exp=7/1", level, overflow); end
    checks++; if (rdata !== 32'd33) begin failures++; $display("FAIL full_wr_rd_data got=%0d exp=33", rdata); end
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    checks++; if ({level, rdata} !== {4'd0, 32'd33}) begin failures++; $display("FAIL sclr_keeps_rdata got=%0d/%0d exp=0/33", level, rdata); end
    wen = 1'b1; ren = 1'b1; wdata = 32'h55;
    tick();
    wen = 1'b0; ren = 1'b0;
    checks++; if ({level, underflow, overflow} !== {4'd1, 2'b10}) begin
      failures++; $display("FAIL empty_wr_rd got=%0d/%b%b exp=1/10", level, underflow, overflow); end
    checks++; if (rdata !== 32'd33) begin failures++; $display("FAIL empty_wr_rd_data got=%0d exp=33", rdata); end
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
  endtask

  task automatic test_sclr();
    for (int i = 0; i < 9; i++) begin
      wen = 1'b1; wdata = 32'(100 + i);
      tick();
    end
    wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ren = 1'b1;
      tick();
    end
    ren = 1'b0;
    checks++; if ({level, overflow, rdata} !== {4'd5, 1'b1, 32'd102}) begin
      failures++; $display("FAIL sclr_pre got=%0d/%b/%0d exp=5/1/102", level, overflow, rdata); end
    sclr = 1'b1; wen = 1'b1; wdata = 32'd200;
    tick();
    sclr = 1'b0; wen = 1'b0;
    checks++; if ({level, overflow, underflow, rempty} !== {4'd0, 3'b001}) begin
      failures++; $display("FAIL sclr_flush got=%0d/%b%b%b exp=0/001", level, overflow, underflow, rempty); end
    checks++; if (rdata !== 32'd102) begin failures++; $display("FAIL sclr_rdata got=%0d exp=102", rdata); end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 3; i++) begin
      wen = 1'b1; wdata = 32'(i);
      tick();
    end
    wen = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if ({level, rempty, wfull, ralmost_empty, walmost_full} !== {4'd0, 4'b1010}) begin
      failures++; $display("FAIL async_rst_flags got=%0d/%b exp=0/1010", level, {rempty, wfull, ralmost_empty, walmost_full}); end
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL async_rst_rdata got=%0d exp=0", rdata); end
    #2;
    rst_n = 1'b1;
    wen = 1'b1; wdata = 32'hAB;
    tick();
    wen = 1'b0;
    checks++; if ({level, rempty} !== {4'd1, 1'b0}) begin failures++; $display("FAIL post_rst_write got=%0d/%b exp=1/0", level, rempty); end
    ren = 1'b1;
    tick();
    ren = 1'b0;
    checks++; if (rdata !== 32'hAB) begin failures++; $display("FAIL post_rst_read got=%0h exp=ab", rdata); end
  endtask

  task automatic test_fwft();
    f_wen = 1'b1; f_wdata = 32'hA5;
    tick();
    f_wen = 1'b0;
    checks++; if ({f_rempty, f_rdata} !== {1'b0, 32'hA5}) begin failures++; $display("FAIL fwft_visible got=%b/%0h exp=0/a5", f_rempty, f_rdata); end
    tick();
    checks++; if ({f_level, f_rdata} !== {4'd1, 32'hA5}) begin failures++; $display("FAIL fwft_hold got=%0d/%0h exp=1/a5", f_level, f_rdata); end
    f_ren = 1'b1;
    tick();
    f_ren = 1'b0;
    checks++; if ({f_rempty, f_level} !== {1'b1, 4'd0}) begin failures++; $display("FAIL fwft_pop got=%b/%0d exp=1/0", f_rempty, f_level); end
    f_wen = 1'b1; f_wdata = 32'h11;
    tick();
    f_wdata = 32'h22;
    tick();
    f_wen = 1'b0;
    checks++; if (f_rdata !== 32'h11) begin failures++; $display("FAIL fwft_head got=%0h exp=11", f_rdata); end
    f_ren = 1'b1;
    tick();
    f_ren = 1'b0;
    checks++; if ({f_rdata, f_level} !== {32'h22, 4'd1}) begin failures++; $display("FAIL fwft_next got=%0h/%0d exp=22/1", f_rdata, f_level); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_simultaneous_edges();
    test_sclr();
    test_async_reset();
    test_fwft();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
